// File: rtl/cplx_fx_pkg.sv
// Shared fixed-point complex types and helpers
// for the packet-sum datapath.
package cplx_fx_pkg;

  localparam int QI_DEF = 3;
  localparam int QF_DEF = 3;
  localparam int W = QI_DEF + QF_DEF;

  typedef struct packed {
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
  } cplx_t;

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  // Same-sign operands with a result of the other sign.
  function automatic logic add_ovf(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [W-1:0] s
  );
    return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endfunction

endpackage

// File: rtl/cplx_sum3_seq_adder3.sv
// Combinational three-input complex adder:
// (a + b) + c per lane, wrapping, with overflow.
module adder3_complex
  import cplx_fx_pkg::*;
(
  input  cplx_t a,
  input  cplx_t b,
  input  cplx_t c,
  output cplx_t sum,
  output logic  ovf
);

  cplx_t t;

  always_comb begin
    t.re   = a.re + b.re;
    t.im   = a.im + b.im;
    sum.re = t.re + c.re;
    sum.im = t.im + c.im;
    ovf    = add_ovf(a.re, b.re, t.re)
           | add_ovf(t.re, c.re, sum.re)
           | add_ovf(a.im, b.im, t.im)
           | add_ovf(t.im, c.im, sum.im);
  end

endmodule

// File: rtl/cplx_sum3_seq.sv
// Packet reducer: two complex terms per beat
// folded into a running sum via one shared adder.
module cplx_sum3_seq
  import cplx_fx_pkg::*;
#(
  parameter int QI    = QI_DEF,
  parameter int QF    = QF_DEF,
  parameter int LEN_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic [LEN_W-1:0]        cfg_len,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [QI+QF-1:0] s_x0_re,
  input  logic signed [QI+QF-1:0] s_x0_im,
  input  logic signed [QI+QF-1:0] s_x1_re,
  input  logic signed [QI+QF-1:0] s_x1_im,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [QI+QF-1:0] m_re,
  output logic signed [QI+QF-1:0] m_im,
  output logic                    m_ovf
);

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] rem;
  cplx_t            acc;
  logic             sticky;

  logic [LEN_W-1:0] cfg_eff;
  logic [LEN_W-1:0] rem_eff;
  logic             last;
  logic             accept;
  cplx_t            x0;
  cplx_t            x1;
  cplx_t            x1m;
  cplx_t            sum;
  logic             pass_ovf;

  assign x0 = '{re: s_x0_re, im: s_x0_im};
  assign x1 = '{re: s_x1_re, im: s_x1_im};

  // Length is sampled only on the first beat of a packet.
  assign cfg_eff = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
  assign rem_eff = (cnt == '0) ? cfg_eff : rem;
  assign last    = rem_eff <= LEN_W'(2);
  assign x1m     = (rem_eff >= LEN_W'(2)) ? x1 : '0;

  assign s_ready = rst_n && (state == ACC);
  assign accept  = s_valid && s_ready && !clr;

  adder3_complex u_add (
    .a   (acc),
    .b   (x0),
    .c   (x1m),
    .sum (sum),
    .ovf (pass_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ACC;
      cnt     <= '0;
      rem     <= '0;
      acc     <= '0;
      sticky  <= 1'b0;
      m_valid <= 1'b0;
      m_re    <= '0;
      m_im    <= '0;
      m_ovf   <= 1'b0;
    end else begin
      unique case (state)
        ACC: begin
          if (clr) begin
            cnt    <= '0;
            acc    <= '0;
            sticky <= 1'b0;
          end else if (accept) begin
            acc    <= sum;
            sticky <= sticky | pass_ovf;
            rem    <= rem_eff - LEN_W'(2);
            cnt    <= cnt + LEN_W'(1);
            if (last) begin
              m_re    <= sum.re;
              m_im    <= sum.im;
              m_ovf   <= sticky | pass_ovf;
              m_valid <= 1'b1;
              state   <= OUT;
            end
          end
        end
        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            sticky  <= 1'b0;
            state   <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_cplx_sum3_seq.sv
// Directed bench for cplx_sum3_seq with
// hand-computed packet sums (W=6, 1.0 = 8).
module tb_cplx_sum3_seq;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr;
  logic [7:0]        cfg_len;
  logic              s_valid;
  logic              s_ready;
  logic signed [5:0] s_x0_re;
  logic signed [5:0] s_x0_im;
  logic signed [5:0] s_x1_re;
  logic signed [5:0] s_x1_im;
  logic              m_valid;
  logic              m_ready;
  logic signed [5:0] m_re;
  logic signed [5:0] m_im;
  logic              m_ovf;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cplx_sum3_seq #(.QI(3), .QF(3), .LEN_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .cfg_len (cfg_len),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_x0_re (s_x0_re),
    .s_x0_im (s_x0_im),
    .s_x1_re (s_x1_re),
    .s_x1_im (s_x1_im),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_re    (m_re),
    .m_im    (m_im),
    .m_ovf   (m_ovf)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int a, input int b, input int c, input int d);
    s_x0_re = 6'(a);
    s_x0_im = 6'(b);
    s_x1_re = 6'(c);
    s_x1_im = 6'(d);
  endtask

  task automatic beat(input int a, input int b, input int c, input int d);
    int n;
    @(negedge clk);
    n = 0;
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      check("beat_timeout", 0, 1);
      return;
    end
    drive(a, b, c, d);
    s_valid = 1'b1;
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic get_result(input string tag, input int re, input int im, input int ovf);
    @(negedge clk);
    check({tag, "_valid"}, m_valid, 1);
    check({tag, "_re"}, m_re, re);
    check({tag, "_im"}, m_im, im);
    check({tag, "_ovf"}, m_ovf, ovf);
    check({tag, "_sready_out"}, s_ready, 0);
    m_ready = 1'b1;
    @(posedge clk);
    #1 m_ready = 1'b0;
    check({tag, "_valid_clr"}, m_valid, 0);
    check({tag, "_sready_back"}, s_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    clr = 1'b0;
    cfg_len = 8'd0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    drive(0, 0, 0, 0);
    #1;
    check("rst_sready", s_ready, 0);
    check("rst_mvalid", m_valid, 0);
    check("rst_mre", m_re, 0);
    check("rst_movf", m_ovf, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check("post_rst_sready", s_ready, 1);

    // basic sum
    cfg_len = 8'd4;
    beat(8, 0, 4, 4);
    check("t1_mid_valid", m_valid, 0);
    beat(-4, 0, 0, -8);
    check("t1_latency", m_valid, 1);
    get_result("t1", 8, -4, 0);

    // odd length masks last x1
    cfg_len = 8'd3;
    beat(8, 8, 8, 8);
    beat(-8, 0, 31, 31);
    get_result("t2", 8, 16, 0);

    // overflow then wrap back, held under backpressure
    cfg_len = 8'd4;
    beat(24, 0, 16, 0);
    beat(-16, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(9, 9, 9, 9);
      s_valid = 1'b1;
      check("t4_hold_valid", m_valid, 1);
      check("t4_hold_re", m_re, 24);
      check("t4_hold_ovf", m_ovf, 1);
      check("t4_hold_sready", s_ready, 0);
    end
    @(negedge clk);
    s_valid = 1'b0;
    get_result("t3", 24, 0, 1);
    cfg_len = 8'd2;
    beat(1, 1, 1, 1);
    get_result("t4_next", 2, 2, 0);

    // clr aborts partial packet, same-cycle beat dropped
    cfg_len = 8'd6;
    beat(5, 5, 5, 5);
    @(negedge clk);
    clr = 1'b1;
    drive(7, 7, 7, 7);
    s_valid = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_clr_novalid", m_valid, 0);
    cfg_len = 8'd2;
    beat(1, 1, 2, 2);
    get_result("t5_clr", 3, 3, 0);

    // async reset mid-packet
    cfg_len = 8'd4;
    beat(10, 10, 10, 10);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_re", m_re, 0);
    check("t5_rst_im", m_im, 0);
    check("t5_rst_valid", m_valid, 0);
    check("t5_rst_sready", s_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cfg_len = 8'd2;
    beat(2, 0, 1, 0);
    get_result("t5_rst", 3, 0, 0);

    // config change mid-packet applies to next packet
    cfg_len = 8'd4;
    beat(1, 0, 1, 0);
    cfg_len = 8'd2;
    check("t6_mid_valid", m_valid, 0);
    beat(1, 0, 1, 0);
    get_result("t6_a", 4, 0, 0);
    beat(3, 3, 3, 3);
    get_result("t6_b", 6, 6, 0);

    // cfg_len=0 acts as 1
    cfg_len = 8'd0;
    beat(3, 4, 9, 9);
    get_result("len0", 3, 4, 0);

    // maximum length, no counter wrap
    cfg_len = 8'd255;
    for (int i = 0; i < 127; i++) beat(0, 0, 0, 0);
    check("lenmax_early", m_valid, 0);
    beat(1, 1, 5, 5);
    get_result("lenmax", 1, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cplx_sum3_seq.md
Name: cplx_sum3_seq

Overview:
- Sequencer that reduces a packet of LEN complex fixed-point terms to one complex sum, using a single shared three-input complex adder.
- Each accepted beat adds two new terms plus the running accumulator in one adder pass.
- Sits between the convolution tap-product stream and the output stage.
- Valid/ready on both sides; sticky per-packet overflow flag.

Parameters:
- QI, 3, integer bits of each fixed-point component (sign included).
- QF, 3, fractional bits.
- LEN_W, 8, width of the packet-length configuration port.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- clr  in  1  synchronous abort of the current packet.
- cfg_len  in  LEN_W  number of terms in the next packet.
- s_valid  in  1  input beat valid.
- s_ready  out  1  block accepts a beat.
- s_x0_re, s_x0_im, s_x1_re, s_x1_im  in  QI+QF each  two signed complex terms per beat.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts the result.
- m_re, m_im  out  QI+QF each  signed packet sum.
- m_ovf  out  1  overflow occurred anywhere in the packet.

Behaviour:
- Reset (rst_n low, asynchronous), all of these go to 0: m_valid, m_re, m_im, m_ovf, accumulator, term counter, sticky overflow. State goes to ACC. s_ready=0 while in reset.
- Widths: W=QI+QF. All adds are two's-complement W-bit, with wrap and no saturation.
- Per-add overflow rule: both operands have the same sign and the result sign differs. Each three-input pass is evaluated as (acc+x0) then (+x1); overflow of either add sets the sticky flag.

State ACC:
- s_ready=1, m_valid=0.
- First beat of a packet (term counter = 0): latch rem = cfg_len. cfg_len=0 is treated as 1. Later changes to cfg_len are ignored until the next packet.
- On s_valid&&s_ready:
  - acc <= acc + x0 + x1', where x1' = x1 if rem >= 2, else 0.
  - sticky |= pass overflow.
  - rem <= rem - 2.
- If the beat had rem <= 2, it is the last beat: on the next edge load m_re/m_im from the new acc, m_ovf from the new sticky, set m_valid=1, and go to OUT.
- Latency: m_valid rises 1 cycle after the last beat handshake.
- Packet occupies ceil(LEN/2) beats. Throughput is one result per ceil(LEN/2)+1 cycles minimum.

State OUT:
- s_ready=0. m_valid, m_re, m_im and m_ovf are held stable until m_ready.
- On m_valid&&m_ready: clear m_valid, acc, sticky and counter; go to ACC. s_ready returns the following cycle.

clr:
- In ACC, clr discards the partial packet: acc, sticky and counter are cleared, and a beat presented in the same cycle is dropped.
- In OUT, clr is ignored; a held result is never lost.
- clr has priority over a simultaneous handshake.

Boundary conditions:
- Reset mid-packet or mid-OUT aborts immediately; no result is emitted.
- LEN odd: the x1 lane of the final beat is masked to zero regardless of its value.
- LEN = max (2^LEN_W - 1): the counter must not wrap; rem is held in LEN_W bits and last is detected as rem <= 2.
- Intermediate overflow that later wraps back to the true value still reports m_ovf=1.

Decomposition:
- Shared package `cplx_fx_pkg`:
  - constant W = QI+QF;
  - a signed complex struct {re, im};
  - state enum {ACC, OUT};
  - an overflow-detect function (sign rule above).
- Natural sub-module: the combinational three-input complex adder `adder3_complex` (existing block), instanced once with inputs acc, x0, x1'. Its overflow output feeds the sticky flag.
- The controller holds only the FSM, counter, accumulator and output registers.

Test Plan:
All values assume QI=3, QF=3 (W=6, 1.0 = raw 8, raw range -32..31).
1. Basic sum: LEN=4, beats (x0=(8,0), x1=(4,4)) then (x0=(-4,0), x1=(0,-8)) -> 1 cycle after beat 2: m_valid=1, m_re=8, m_im=-4, m_ovf=0.
2. Odd length: LEN=3, beats (8,8),(8,8) then (x0=(-8,0), x1=(31,31)) -> m_re=8, m_im=16, m_ovf=0; x1 of the last beat is ignored.
3. Overflow with recovery: LEN=4, re lane beats (24,16) then (-16,0) -> acc goes -24, then 24; m_re=24, m_ovf=1.
4. Backpressure: hold m_ready=0 for 5 cycles after m_valid -> m_re, m_im and m_ovf stay stable, s_ready=0, beats presented are not consumed. Result transfers on the first m_ready=1 cycle; s_ready=1 the cycle after.
5. Abort paths: LEN=6, assert clr after beat 1 -> no result, next packet LEN=2 (x0=(1,1), x1=(2,2)) gives (3,3) with ovf=0. Repeat with rst_n pulsed low mid-packet: all outputs 0 immediately.
6. Config stability: LEN=4, change cfg_len to 2 after beat 1 -> packet still takes 2 beats. The new value applies only to the following packet, which completes after 1 beat.
